// File: rtl/demux_pkg.sv
// Shared types and helpers for the sequential 1:16 demultiplexer.
// The PARITY state is only reachable when DEMUX_PARITY_EN is defined.
package demux_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        PARITY = 2'd1,
        HOLD   = 2'd2
    } demux_state_t;

    function automatic int NUM_SLOTS(input int sel_w);
        return 1 << sel_w;
    endfunction

endpackage

// File: rtl/demux1_16_seq_if.sv
// Bit-in / word-out handshake bundle for demux1_16_seq.
// parity_err exists only when DEMUX_PARITY_EN is defined.
interface demux1_16_seq_if #(
    parameter int SEL_W = 4
) ();

    localparam int NS = demux_pkg::NUM_SLOTS(SEL_W);

    logic             auto_mode;
    logic [SEL_W-1:0] sel;
    logic             in_bit;
    logic             in_valid;
    logic             in_ready;
    logic [NS-1:0]    out;
    logic             out_valid;
    logic             out_ready;
`ifdef DEMUX_PARITY_EN
    logic             parity_err;
`endif

    // master = serial source plus word consumer; slave = the demux itself
    modport master (
        output auto_mode, sel, in_bit, in_valid, out_ready,
        input  in_ready, out, out_valid
`ifdef DEMUX_PARITY_EN
        , input parity_err
`endif
    );

    modport slave (
        input  auto_mode, sel, in_bit, in_valid, out_ready,
        output in_ready, out, out_valid
`ifdef DEMUX_PARITY_EN
        , output parity_err
`endif
    );

endinterface

// File: rtl/slot_counter.sv
// Wrapping slot counter used as the write pointer in auto mode.
module slot_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    // Clear has priority so a frame hand-off always restarts at slot 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/demux1_16_seq.sv
// Sequential 1:16 demux/deserializer: steers one bit per beat into a slot, then holds the word.
// Optional trailing even-parity beat enabled by `define DEMUX_PARITY_EN.
module demux1_16_seq
    import demux_pkg::*;
#(
    parameter int SEL_W = 4
) (
    input  logic           clk,
    input  logic           reset,
    demux1_16_seq_if.slave bus
);

    localparam int NS = NUM_SLOTS(SEL_W);

    demux_state_t     state_q, state_d;
    logic [NS-1:0]    out_q, out_d;
    logic [NS-1:0]    mask_q, mask_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [SEL_W-1:0] cnt;
    logic [SEL_W-1:0] slot;
    logic [NS-1:0]    slot_oh;
    logic             beat;
    logic             cnt_en;
    logic             cnt_clr;
`ifdef DEMUX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    assign beat    = bus.in_valid & in_ready_q;
    assign slot    = bus.auto_mode ? cnt : bus.sel;
    assign slot_oh = NS'(1) << slot;

    slot_counter #(.W(SEL_W)) u_slot_counter (
        .clk   (clk),
        .reset (reset),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .cnt_o (cnt)
    );

    // Completion is decided by the written-slot mask in both modes, so mixing modes mid-frame stays safe
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        mask_d  = mask_q;
        cnt_en  = 1'b0;
        cnt_clr = 1'b0;
`ifdef DEMUX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            FILL: begin
                if (beat) begin
                    out_d  = (out_q & ~slot_oh) | (bus.in_bit ? slot_oh : '0);
                    mask_d = mask_q | slot_oh;
                    cnt_en = bus.auto_mode;
                    if (&mask_d) begin
`ifdef DEMUX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = HOLD;
`endif
                    end
                end
            end
`ifdef DEMUX_PARITY_EN
            PARITY: begin
                if (beat) begin
                    parity_d = (^out_q) ^ bus.in_bit;
                    state_d  = HOLD;
                end
            end
`endif
            HOLD: begin
                if (out_valid_q && bus.out_ready) begin
                    state_d = FILL;
                    mask_d  = '0;
                    cnt_clr = 1'b1;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Handshake flags are registered from next state so out_ready never reaches in_ready combinationally
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= FILL;
            out_q       <= '0;
            mask_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            mask_q      <= mask_d;
            in_ready_q  <= (state_d != HOLD);
            out_valid_q <= (state_d == HOLD);
        end
    end

`ifdef DEMUX_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign bus.parity_err = parity_q;
`endif

    assign bus.in_ready  = in_ready_q;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;

endmodule
